// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
// Purpose: bundles the term-input handshake, group control and result-output
//          handshake of the partial-sum accumulator into one interface.
// Signals:
//   clear      group flush request (synchronous)
//   acc_len    terms per group minus 1, sampled on the first term of a group
//   in_valid   a carry-save term is offered
//   in_ready   accumulator accepts a term this cycle
//   in_sum     sum vector of the term
//   in_carry   weight-aligned carry vector of the term
//   out_valid  out_data/out_ovf hold a completed group
//   out_ready  downstream consumes the result
//   out_data   signed accumulated group result
//   out_ovf    signed overflow happened somewhere in the group
// Modports: master = producer/consumer side, slave = accumulator side.
interface psum_accumulator_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20
);
  logic             clear;
  logic [5:0]       acc_len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output clear, acc_len, in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  clear, acc_len, in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Purpose: resolves carry-save terms (sum + carry) from a compressor tree and
//          accumulates groups of 1..64 signed terms into an ACC_W-bit result,
//          flagging signed overflow anywhere in the group. One term per cycle;
//          the completed result is held until downstream takes it.
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   bus   psum_accumulator_if slave modport (term input, control, result)
module psum_accumulator #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 20
) (
  input  logic                clk,
  input  logic                rst,
  psum_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [5:0]       cnt;
  logic [5:0]       len_q;
  logic             ovf;

  logic [WIDTH-1:0] term_raw;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             accept;
  logic             last_term;

  // Final carry-propagate add of the carry-save pair wraps at WIDTH bits;
  // the result is a two's complement value sign-extended to accumulator width.
  assign term_raw = bus.in_sum + bus.in_carry;
  assign term     = {{(ACC_W-WIDTH){term_raw[WIDTH-1]}}, term_raw};
  assign sum      = acc + term;

  // Signed overflow: both operands share a sign but the wrapped sum does not.
  assign add_ovf  = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  assign bus.in_ready = (state != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  // cnt is the 0-based index of the last accepted term, so the incoming term
  // is number cnt+1; the group never runs past len_q so this cannot wrap.
  assign last_term = ((cnt + 6'd1) == len_q);

  // Single-process FSM. The result registers are loaded on the same edge that
  // enters HOLD so out_valid rises the cycle after the final term, and they
  // are left alone afterwards so the last result stays visible in IDLE/ACCUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      len_q         <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
    end else if (bus.clear) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= term;
            cnt   <= '0;
            len_q <= bus.acc_len;
            ovf   <= 1'b0;
            if (bus.acc_len == 6'd0) begin
              state         <= HOLD;
              bus.out_valid <= 1'b1;
              bus.out_data  <= term;
              bus.out_ovf   <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt + 6'd1;
            ovf <= ovf | add_ovf;
            if (last_term) begin
              state         <= HOLD;
              bus.out_valid <= 1'b1;
              bus.out_data  <= sum;
              bus.out_ovf   <= ovf | add_ovf;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
// Purpose: directed self-checking bench for psum_accumulator. Each task covers
//          one scenario with hand-computed expected values.
// Ports: none (top-level bench).
module tb_psum_accumulator;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  psum_accumulator_if #(.WIDTH(16), .ACC_W(20)) bus ();

  psum_accumulator #(.WIDTH(16), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one term for exactly one clock edge, then sample 1 time unit later.
  task automatic push(input logic [15:0] s, input logic [15:0] c);
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_carry = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 20'h0) begin failures++; $display("[TB] FAIL reset_data: got %0h expected 0", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %0h expected 0", bus.out_ovf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %0h expected 1", bus.in_ready); end
  endtask

  // (5,3)=8, (10,0)=10, (0x8000,0x8000)=0 after wrap, (1,2)=3 -> 21
  task automatic test_basic_group();
    bus.out_ready = 1'b1;
    bus.acc_len   = 6'd3;
    push(16'd5, 16'd3);
    push(16'd10, 16'd0);
    push(16'h8000, 16'h8000);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid: got %0h expected 0", bus.out_valid); end
    push(16'd1, 16'd2);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'd21) begin failures++; $display("[TB] FAIL basic_data: got %0h expected %0h", bus.out_data, 20'd21); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("[TB] FAIL basic_ovf: got %0h expected 0", bus.out_ovf); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_hold_ready: got %0h expected 0", bus.in_ready); end
    idle_cycle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL basic_release_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_release_ready: got %0h expected 1", bus.in_ready); end
    checks++; if (bus.out_data !== 20'd21) begin failures++; $display("[TB] FAIL basic_data_kept: got %0h expected %0h", bus.out_data, 20'd21); end
  endtask

  // -1 + -2 = -3 -> 0xFFFFD in 20 bits, no overflow
  task automatic test_negative_terms();
    bus.acc_len = 6'd1;
    push(16'hFFFF, 16'h0000);
    push(16'hFFFE, 16'h0000);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL neg_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'hFFFFD) begin failures++; $display("[TB] FAIL neg_data: got %0h expected %0h", bus.out_data, 20'hFFFFD); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("[TB] FAIL neg_ovf: got %0h expected 0", bus.out_ovf); end
    idle_cycle();
  endtask

  // 17 * 0x7FFF = 557039 = 0x87FEF; exceeds +524287 so overflow is sticky
  task automatic test_overflow();
    bus.acc_len = 6'd16;
    for (int i = 0; i < 16; i++) push(16'h7FFF, 16'h0000);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early_valid: got %0h expected 0", bus.out_valid); end
    push(16'h7FFF, 16'h0000);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL ovf_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'h87FEF) begin failures++; $display("[TB] FAIL ovf_data: got %0h expected %0h", bus.out_data, 20'h87FEF); end
    checks++; if (bus.out_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag: got %0h expected 1", bus.out_ovf); end
    idle_cycle();
  endtask

  // Result stalls 5 cycles with a term pending; the stalled term must not be
  // taken, including in the handshake cycle, then is taken once back in IDLE.
  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    bus.acc_len   = 6'd0;
    push(16'd9, 16'd0);
    checks++; if (bus.out_data !== 20'd9) begin failures++; $display("[TB] FAIL stall_first_data: got %0h expected 9", bus.out_data); end
    bus.in_valid = 1'b1;
    bus.in_sum   = 16'd1;
    bus.in_carry = 16'd0;
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready_%0d: got %0h expected 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid_%0d: got %0h expected 1", i, bus.out_valid); end
      checks++; if (bus.out_data !== 20'd9) begin failures++; $display("[TB] FAIL stall_data_%0d: got %0h expected 9", i, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    idle_cycle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_ready: got %0h expected 1", bus.in_ready); end
    push(16'd1, 16'd0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_next_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'd1) begin failures++; $display("[TB] FAIL stall_next_data: got %0h expected 1", bus.out_data); end
    idle_cycle();
  endtask

  // Clear drops a partial group and the term offered with it; acc_len is then
  // changed mid-group, which must not shorten the new 4-term group.
  task automatic test_clear();
    bus.out_ready = 1'b1;
    bus.acc_len   = 6'd3;
    push(16'd5, 16'd0);
    push(16'd6, 16'd0);
    bus.clear = 1'b1;
    push(16'd100, 16'd0);
    bus.clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL clear_ready: got %0h expected 1", bus.in_ready); end
    push(16'd1, 16'd0);
    bus.acc_len = 6'd0;
    push(16'd1, 16'd0);
    push(16'd1, 16'd0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_len_change_valid: got %0h expected 0", bus.out_valid); end
    push(16'd1, 16'd0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL clear_group_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'd4) begin failures++; $display("[TB] FAIL clear_group_data: got %0h expected 4", bus.out_data); end
    idle_cycle();
    bus.out_ready = 1'b0;
    push(16'd2, 16'd0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL clear_hold_setup: got %0h expected 1", bus.out_valid); end
    bus.clear = 1'b1;
    idle_cycle();
    bus.clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL clear_hold_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL clear_hold_ready: got %0h expected 1", bus.in_ready); end
  endtask

  // Reset asserted between clock edges must clear outputs at once.
  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    bus.acc_len   = 6'd3;
    push(16'd5, 16'd0);
    push(16'd6, 16'd0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_data !== 20'd0) begin failures++; $display("[TB] FAIL arst_accum_data: got %0h expected 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL arst_accum_ready: got %0h expected 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) push(16'd1, 16'd0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_lost_group_valid: got %0h expected 0", bus.out_valid); end
    push(16'd1, 16'd0);
    checks++; if (bus.out_data !== 20'd4) begin failures++; $display("[TB] FAIL arst_lost_group_data: got %0h expected 4", bus.out_data); end
    idle_cycle();
    bus.out_ready = 1'b0;
    bus.acc_len   = 6'd0;
    push(16'd3, 16'd0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_hold_setup: got %0h expected 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL arst_hold_valid: got %0h expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 20'd0) begin failures++; $display("[TB] FAIL arst_hold_data: got %0h expected 0", bus.out_data); end
    checks++; if (bus.out_ovf !== 1'b0) begin failures++; $display("[TB] FAIL arst_hold_ovf: got %0h expected 0", bus.out_ovf); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push(16'd7, 16'd0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL arst_after_valid: got %0h expected 1", bus.out_valid); end
    checks++; if (bus.out_data !== 20'd7) begin failures++; $display("[TB] FAIL arst_after_data: got %0h expected 7", bus.out_data); end
    idle_cycle();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.acc_len   = 6'd0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = 16'd0;
    bus.in_carry  = 16'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_group();
    test_negative_terms();
    test_overflow();
    test_hold_stall();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a stuck run; every scenario above is a fixed cycle count.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter WIDTH, default 16: width of the carry-save input pair and of the final-add result.
REQ-002 Parameter ACC_W, default 20: accumulator and output width; ACC_W SHALL be greater than WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of the group in progress and of any held result.
REQ-006 acc_len  input  6  number of terms per group minus 1 (1..64 terms); sampled on the first term of each group.
REQ-007 in_valid  input  1  a carry-save term is present.
REQ-008 in_ready  output  1  block accepts a term this cycle.
REQ-009 in_sum  input  WIDTH  sum vector from the compressor tree.
REQ-010 in_carry  input  WIDTH  carry vector from the compressor tree, already weight-aligned.
REQ-011 out_valid  output  1  out_data and out_ovf hold a completed group.
REQ-012 out_ready  input  1  downstream consumes the result.
REQ-013 out_data  output  ACC_W  signed accumulated group result.
REQ-014 out_ovf  output  1  signed overflow occurred during this group.

Function
REQ-015 A term SHALL be accepted exactly on cycles where in_valid and in_ready are both 1.
REQ-016 Term value = (in_sum + in_carry) mod 2^WIDTH, interpreted as two's complement and sign-extended to ACC_W bits.
REQ-017 States: IDLE (no partial group), ACCUM (partial group), HOLD (result waiting).
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 IDLE, term accepted: acc <= term, cnt <= 0, len_q <= acc_len, ovf <= 0; go to ACCUM, or directly to HOLD if acc_len = 0.
REQ-020 ACCUM, term accepted: acc <= acc + term mod 2^ACC_W; cnt <= cnt + 1; go to HOLD when the accepted term is number len_q (0-based).
REQ-021 ovf SHALL be set sticky when a signed addition in REQ-020 overflows ACC_W (operand signs equal, result sign differs); acc wraps.
REQ-022 ACCUM with no accepted term: all state holds; the group has no timeout.
REQ-023 HOLD: out_valid = 1, out_data = acc, out_ovf = ovf; all three SHALL remain stable until out_ready = 1.
REQ-024 HOLD with out_ready = 1: go to IDLE next cycle; out_valid deasserts that cycle; no term is accepted in that handshake cycle.
REQ-025 Latency: out_valid SHALL rise the cycle after the last term of a group is accepted.
REQ-026 In IDLE and ACCUM, out_valid = 0; out_data and out_ovf SHALL hold their last values.
REQ-027 clear = 1 SHALL have priority over all handshakes: next state IDLE, acc = 0, cnt = 0, ovf = 0, out_valid = 0; any term offered that cycle and any held result are discarded.
REQ-028 A change of acc_len mid-group SHALL not affect the group in progress.
REQ-029 Throughput: one term per cycle in IDLE and ACCUM; one bubble cycle per group (HOLD->IDLE).

Reset
REQ-030 While rst = 1, regardless of clk: state = IDLE, acc = 0, cnt = 0, len_q = 0, ovf = 0, out_valid = 0, out_data = 0, out_ovf = 0.
REQ-031 in_ready = 1 after reset release; a group partially accumulated when rst asserts SHALL be lost without producing out_valid.

Verification
REQ-032 acc_len=3; terms (5,3), (10,0), (0x8000,0x8000), (1,2); out_ready=1 -> out_valid one cycle after the fourth acceptance, out_data=21, out_ovf=0.
REQ-033 acc_len=1; terms (0xFFFF,0), (0xFFFE,0) -> out_data=0xFFFFD (-3, ACC_W=20), out_ovf=0.
REQ-034 acc_len=16; 17 terms of (0x7FFF,0) -> out_data=0x87FEF (557039 wrapped mod 2^20), out_ovf=1.
REQ-035 Group complete, out_ready held 0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable for all 5 cycles; out_ready=1 -> IDLE next cycle, next term accepted.
REQ-036 acc_len=3; two terms accepted, then clear=1 with in_valid=1 -> term dropped; the following 4 terms (1,0) each -> out_data=4.
REQ-037 rst asserted asynchronously mid-group and mid-HOLD -> all outputs 0 immediately; after release, acc_len=0 with term (7,0) -> out_data=7 on the next cycle.
